// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package control_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_R_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_LW_WB,
    S_MEM_WR,
    S_BRANCH
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_XOR = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle controller and its datapath/memory.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Opcode;
  logic             Zero;
  logic             mem_ready;
  logic [1:0]       ALUControl;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             IRWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             PCSource;
  logic             PCWriteEn;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  Opcode, Zero, mem_ready,
    output ALUControl, ALUSrcA, ALUSrcB, MemRead, MemWrite, IorD, IRWrite,
           RegWrite, RegDst, MemtoReg, PCSource, PCWriteEn, illegal_op, retired
  );

  modport slave (
    output Opcode, Zero, mem_ready,
    input  ALUControl, ALUSrcA, ALUSrcB, MemRead, MemWrite, IorD, IRWrite,
           RegWrite, RegDst, MemtoReg, PCSource, PCWriteEn, illegal_op, retired
  );
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Opcode to ALU operation map; also flags opcodes outside the supported ISA.
module alu_op_decode
  import control_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [1:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_LW, OP_SW, OP_BEQ: alu_op = ALU_ADD;
      OP_SUB:                       alu_op = ALU_SUB;
      OP_XOR:                       alu_op = ALU_XOR;
      default:                      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencing fetch/decode/execute/memory/writeback with a retire counter.
module multicycle_control
  import control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic [1:0]       dec_alu_op;
  logic             dec_illegal;

  logic [1:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       pc_source;
  logic       pc_write;
  logic       pc_write_cond;
  logic       illegal;

  alu_op_decode u_alu_op_decode (
    .opcode  (bus.Opcode),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      retired_q <= '0;
    end else begin
      state <= state_nx;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx      = state;
    alu_control   = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    pc_source     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    illegal       = 1'b0;
    retire        = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR load and PC+4 commit only on the edge the memory completes
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        if (dec_illegal) begin
          illegal  = 1'b1;
          state_nx = S_FETCH;
        end else begin
          case (bus.Opcode)
            OP_LW, OP_SW: state_nx = S_MEM_ADDR;
            OP_BEQ:       state_nx = S_BRANCH;
            default:      state_nx = S_EXEC_R;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = dec_alu_op;
        state_nx    = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nx  = (bus.Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_nx = S_LW_WB;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_control   = ALU_SUB;
        pc_source     = 1'b1;
        pc_write_cond = 1'b1;
        retire        = 1'b1;
        state_nx      = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.ALUControl = alu_control;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.IorD       = iord;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.PCSource   = pc_source;
  assign bus.PCWriteEn  = pc_write | (pc_write_cond & bus.Zero);
  assign bus.illegal_op = illegal;
  assign bus.retired    = retired_q;

endmodule
